// File: rtl/instr_ram_dp.sv
// instr_ram_dp: dual-port instruction RAM, port A read-only fetch with 1/2-cycle latency, port B byte-enabled program/debug read/write
module instr_ram_dp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int RD_LATENCY  = 1,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_rd_req,
  output logic        a_rd_gnt,
  input  logic [31:0] a_rd_addr,
  output logic [31:0] a_rd_data,
  output logic        a_rd_err,
  input  logic        b_rd_req,
  output logic        b_rd_gnt,
  input  logic [31:0] b_rd_addr,
  output logic [31:0] b_rd_data,
  input  logic        b_wr_req,
  output logic        b_wr_gnt,
  input  logic [31:0] b_wr_addr,
  input  logic [31:0] b_wr_data,
  input  logic [3:0]  b_wr_be,
  input  logic        wp,
  output logic        b_err
);
  localparam int AW = (IDX_W < 1) ? 1 : IDX_W;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] a_d1;
  logic        a_e1, a_ok, b_rd_ok, b_wr_ok, b_wr_en;
  logic [AW-1:0] a_idx, b_rd_idx, b_wr_idx;
  assign a_rd_gnt = a_rd_req;
  assign b_rd_gnt = b_rd_req;
  assign b_wr_gnt = b_wr_req;
  assign a_ok     = {2'b00, a_rd_addr[31:2]} < 32'(DEPTH_WORDS);
  assign b_rd_ok  = {2'b00, b_rd_addr[31:2]} < 32'(DEPTH_WORDS);
  assign b_wr_ok  = {2'b00, b_wr_addr[31:2]} < 32'(DEPTH_WORDS);
  assign a_idx    = a_rd_addr[AW+1:2];
  assign b_rd_idx = b_rd_addr[AW+1:2];
  assign b_wr_idx = b_wr_addr[AW+1:2];
  assign b_wr_en  = b_wr_req && !wp && b_wr_ok;
  always_ff @(posedge clk)
    if (b_wr_en)
      for (int i = 0; i < 4; i++)
        if (b_wr_be[i]) mem[b_wr_idx][8*i +: 8] <= b_wr_data[8*i +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_d1      <= '0;
      a_e1      <= 1'b0;
      b_rd_data <= '0;
      b_err     <= 1'b0;
    end else begin
      a_d1      <= (a_rd_req && a_ok) ? mem[a_idx] : '0;
      a_e1      <= a_rd_req && !a_ok;
      b_rd_data <= (b_rd_req && b_rd_ok) ? mem[b_rd_idx] : '0;
      b_err     <= b_wr_req && (wp || !b_wr_ok);
    end
  if (RD_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        a_rd_data <= '0;
        a_rd_err  <= 1'b0;
      end else begin
        a_rd_data <= a_d1;
        a_rd_err  <= a_e1;
      end
  end else begin : g_lat1
    assign a_rd_data = a_d1;
    assign a_rd_err  = a_e1;
  end
endmodule
